// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared Viterbi link constants, symbol type and encoder FSM states
//   K         constraint length
//   G0, G1    generator taps, MSB applies to the current input bit
//   sym_t     2-bit channel symbol {G0 bit, G1 bit}
//   conv_sym  symbol produced by input u from register state sr
package viterbi_pkg;

  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_t;

  // Window is {u, d(n-1), d(n-2)}; each output bit is the parity of the tapped window.
  function automatic sym_t conv_sym(input logic u, input logic [K-2:0] sr);
    logic [K-1:0] win;
    win = {u, sr};
    return {^(win & G0), ^(win & G1)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// rtl/conv_enc_core.sv - K=3 rate-1/2 convolutional encoder shift register
//   clk  in   clock
//   rst  in   asynchronous active-low reset, clears the register to 00
//   adv  in   shift u into the register this cycle
//   u    in   input bit for the current symbol
//   g    out  {G0, G1} for u against the current register state
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic adv,
  input  logic u,
  output sym_t g
);

  // sr[K-2] is d(n-1), sr[0] is the oldest bit.
  logic [K-2:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (adv) begin
      sr <= {u, sr[K-2:1]};
    end
  end

  assign g = conv_sym(u, sr);

endmodule

// File: rtl/conv_encoder_framer.sv
// rtl/conv_encoder_framer.sv - frames a serial bit stream, convolutionally encodes it and appends a zero tail
//   Optional feature macro: ERR_INJ_EN (deterministic bit[1] corruption every ERR_PERIOD symbols)
//   clk               in   clock
//   rst               in   asynchronous active-low reset
//   enable_encoder_i  in   permits data acceptance and new frame start
//   data_i            in   input data bit
//   data_valid_i      in   data_i valid
//   data_ready_o      out  data_i accepted this cycle when valid
//   sym_o             out  {G0, G1} channel symbol after injection
//   sym_valid_o       out  sym_o valid
//   sym_ready_i       in   downstream takes sym_o
//   sof_o             out  sym_o is the first symbol of a frame
//   eof_o             out  sym_o is the last tail symbol of a frame
//   word_ct_o         out  frames fully emitted, wraps
//   err_inj_o         out  flip mask applied to sym_o
//   error_counter_o   out  corrupted symbols emitted, wraps
module conv_encoder_framer
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN  = 64,
  parameter int ERR_PERIOD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_encoder_i,
  input  logic        data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  output sym_t        sym_o,
  output logic        sym_valid_o,
  input  logic        sym_ready_i,
  output logic        sof_o,
  output logic        eof_o,
  output logic [15:0] word_ct_o,
  output sym_t        err_inj_o,
  output logic [15:0] error_counter_o
);

  // Wide enough to hold FRAME_LEN itself, which bit_cnt reaches during the tail.
  localparam int CW = $clog2(FRAME_LEN + 1);

  enc_state_t    state, state_nxt;
  logic [CW-1:0] bit_cnt;
  logic          tail_cnt;
  logic          slot_free;
  logic          accept;
  logic          tail_enc;
  logic          encode;
  logic          u;
  logic          last_bit;
  logic          last_tail;
  sym_t          g;
  sym_t          inj_mask;

  // The output register can take a new symbol if empty or being drained this cycle.
  assign slot_free = !sym_valid_o | sym_ready_i;
  assign last_bit  = (bit_cnt == CW'(FRAME_LEN - 1));
  assign last_tail = tail_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable_encoder_i) state_nxt = DATA;
      DATA: if (accept && last_bit) state_nxt = TAIL;
      TAIL: if (tail_enc && last_tail) state_nxt = enable_encoder_i ? DATA : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tail symbols are forced out regardless of enable so a started frame always terminates.
  always_comb begin
    data_ready_o = 1'b0;
    tail_enc     = 1'b0;
    case (state)
      DATA:    data_ready_o = enable_encoder_i & slot_free;
      TAIL:    tail_enc     = slot_free;
      default: ;
    endcase
  end

  assign accept = data_valid_i & data_ready_o;
  assign encode = accept | tail_enc;
  assign u      = accept & data_i;

  conv_enc_core u_core (
    .clk (clk),
    .rst (rst),
    .adv (encode),
    .u   (u),
    .g   (g)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= '0;
      tail_cnt <= 1'b0;
    end else begin
      if (accept) bit_cnt <= bit_cnt + 1'b1;
      if (tail_enc) begin
        tail_cnt <= ~tail_cnt;
        if (last_tail) bit_cnt <= '0;
      end
    end
  end

`ifdef ERR_INJ_EN
  localparam int IW = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;

  logic [IW-1:0] inj_cnt;
  logic          inj_hit;

  assign inj_hit  = (inj_cnt == IW'(ERR_PERIOD - 1));
  assign inj_mask = inj_hit ? 2'b10 : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inj_cnt         <= '0;
      error_counter_o <= '0;
    end else if (encode) begin
      inj_cnt <= inj_hit ? '0 : inj_cnt + 1'b1;
      if (inj_hit) error_counter_o <= error_counter_o + 16'd1;
    end
  end
`else
  // ERR_PERIOD only matters when injection is built in.
  logic unused_err_period;
  assign unused_err_period = (ERR_PERIOD < 2);
  assign inj_mask          = 2'b00;
  assign error_counter_o   = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_o       <= '0;
      sym_valid_o <= 1'b0;
      sof_o       <= 1'b0;
      eof_o       <= 1'b0;
      err_inj_o   <= '0;
    end else if (encode) begin
      sym_o       <= g ^ inj_mask;
      sym_valid_o <= 1'b1;
      sof_o       <= accept && (bit_cnt == '0);
      eof_o       <= tail_enc && last_tail;
      err_inj_o   <= inj_mask;
    end else if (sym_valid_o && sym_ready_i) begin
      sym_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_ct_o <= '0;
    end else if (sym_valid_o && sym_ready_i && eof_o) begin
      word_ct_o <= word_ct_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// tb/tb_conv_encoder_framer.sv - directed self-checking bench for conv_encoder_framer
module tb_conv_encoder_framer;

  localparam int FL = 4;
  localparam int EP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_encoder_i = 1'b0;
  logic        data_i = 1'b0;
  logic        data_valid_i = 1'b0;
  logic        sym_ready_i = 1'b1;
  logic        data_ready_o;
  logic [1:0]  sym_o;
  logic        sym_valid_o;
  logic        sof_o;
  logic        eof_o;
  logic [15:0] word_ct_o;
  logic [1:0]  err_inj_o;
  logic [15:0] error_counter_o;

  conv_encoder_framer #(.FRAME_LEN(FL), .ERR_PERIOD(EP)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_encoder_i (enable_encoder_i),
    .data_i           (data_i),
    .data_valid_i     (data_valid_i),
    .data_ready_o     (data_ready_o),
    .sym_o            (sym_o),
    .sym_valid_o      (sym_valid_o),
    .sym_ready_i      (sym_ready_i),
    .sof_o            (sof_o),
    .eof_o            (eof_o),
    .word_ct_o        (word_ct_o),
    .err_inj_o        (err_inj_o),
    .error_counter_o  (error_counter_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Model of the injector: the n-th symbol loaded since reset (1-based) is hit when n % EP == 0.
  function automatic logic [1:0] exp_mask(input int idx);
`ifdef ERR_INJ_EN
    return (idx % EP == 0) ? 2'b10 : 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  int         cyc = 0;
  int         sym_idx = 0;
  int         n_err_model = 0;
  logic [1:0] q_sym[$];
  logic [1:0] q_mask[$];
  logic [1:0] q_emask[$];
  logic       q_sof[$];
  logic       q_eof[$];
  int         q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // A symbol valid and ready at the falling edge is taken at the next rising edge.
  always @(negedge clk) begin
    if (rst && sym_valid_o && sym_ready_i) begin
      sym_idx++;
      if (exp_mask(sym_idx) != 2'b00) n_err_model++;
      q_sym.push_back(sym_o);
      q_mask.push_back(err_inj_o);
      q_emask.push_back(exp_mask(sym_idx));
      q_sof.push_back(sof_o);
      q_eof.push_back(eof_o);
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_queues();
    q_sym.delete(); q_mask.delete(); q_emask.delete();
    q_sof.delete(); q_eof.delete(); q_cyc.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_queues();
    sym_idx = 0;
    n_err_model = 0;
    rst = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    int t;
    t = 0;
    data_i = b;
    data_valid_i = 1'b1;
    @(negedge clk);
    while (!data_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!data_ready_o) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    data_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) send_bit(bits[i]);
  endtask

  // exp holds six symbols, first symbol in the top two bits.
  task automatic check_frame(input string tag, input logic [11:0] exp);
    int t;
    logic [1:0] s, m, em;
    logic sf, ef;
    t = 0;
    while (q_sym.size() < 6 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q_sym.size() < 6) begin
      check({tag, "_timeout"}, q_sym.size(), 6);
    end else begin
      for (int i = 0; i < 6; i++) begin
        s = q_sym.pop_front(); m = q_mask.pop_front(); em = q_emask.pop_front();
        sf = q_sof.pop_front(); ef = q_eof.pop_front();
        check($sformatf("%s_sym%0d", tag, i), s, exp[11-2*i -: 2] ^ em);
        check($sformatf("%s_mask%0d", tag, i), m, em);
        check($sformatf("%s_sof%0d", tag, i), sf, i == 0);
        check($sformatf("%s_eof%0d", tag, i), ef, i == 5);
      end
    end
    @(posedge clk); #1;
  endtask

  localparam logic [11:0] FR_1011 = 12'b11_10_00_01_01_11;
  localparam logic [11:0] FR_1111 = 12'b11_01_10_10_01_11;

  initial begin
    #1;
    check("rst_sym", sym_o, 2'b00);
    check("rst_valid", sym_valid_o, 1'b0);
    check("rst_sof", sof_o, 1'b0);
    check("rst_eof", eof_o, 1'b0);
    check("rst_ready", data_ready_o, 1'b0);
    check("rst_word_ct", word_ct_o, 16'd0);
    check("rst_err_inj", err_inj_o, 2'b00);
    check("rst_err_cnt", error_counter_o, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", data_ready_o, 1'b0);
    @(posedge clk); #1;

    // Single frame 1,0,1,1
    enable_encoder_i = 1'b1;
    send_frame(4'b1011);
    check_frame("f1", FR_1011);
    check("f1_word_ct", word_ct_o, 16'd1);

    // Two back-to-back all-ones frames from a fresh reset
    apply_reset();
    q_cyc.delete();
    send_frame(4'b1111);
    send_frame(4'b1111);
    while (q_cyc.size() < 12 && cyc < 5000) @(negedge clk);
    if (q_cyc.size() >= 12) check("b2b_span", q_cyc[11] - q_cyc[0], 11);
    else check("b2b_timeout", q_cyc.size(), 12);
    check_frame("b2b_a", FR_1111);
    check_frame("b2b_b", FR_1111);
    check("b2b_word_ct", word_ct_o, 16'd2);
`ifdef ERR_INJ_EN
    check("b2b_err_cnt", error_counter_o, 16'd3);
`endif
    check("b2b_err_cnt_model", error_counter_o, n_err_model);

    // Downstream stall for 5 cycles after the second bit
    send_bit(1'b1);
    send_bit(1'b0);
    sym_ready_i = 1'b0;
    data_i = 1'b1;
    data_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_ready%0d", i), data_ready_o, 1'b0);
      check($sformatf("stall_sym%0d", i), sym_o, 2'b10 ^ exp_mask(sym_idx + 1));
      check($sformatf("stall_valid%0d", i), sym_valid_o, 1'b1);
      @(posedge clk); #1;
    end
    sym_ready_i = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    check_frame("stall", FR_1011);
    check("stall_word_ct", word_ct_o, 16'd3);

    // Enable dropped for 10 cycles after two bits
    send_bit(1'b1);
    send_bit(1'b0);
    enable_encoder_i = 1'b0;
    data_i = 1'b1;
    data_valid_i = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("pause_valid%0d", i), sym_valid_o, 1'b0);
      check($sformatf("pause_ready%0d", i), data_ready_o, 1'b0);
      @(posedge clk); #1;
    end
    check("pause_count", q_sym.size(), 2);
    enable_encoder_i = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    check_frame("pause", FR_1011);
    check("pause_word_ct", word_ct_o, 16'd4);

    // Reset in the middle of a frame
    apply_reset();
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b0;
    #1;
    check("mrst_sym", sym_o, 2'b00);
    check("mrst_valid", sym_valid_o, 1'b0);
    check("mrst_sof", sof_o, 1'b0);
    check("mrst_eof", eof_o, 1'b0);
    check("mrst_ready", data_ready_o, 1'b0);
    check("mrst_word_ct", word_ct_o, 16'd0);
    check("mrst_err_cnt", error_counter_o, 16'd0);
    check("mrst_err_inj", err_inj_o, 2'b00);
    @(posedge clk); #1;
    clear_queues();
    sym_idx = 0;
    n_err_model = 0;
    rst = 1'b1;
    send_frame(4'b1011);
    check_frame("mrst", FR_1011);
    check("mrst_word_ct_after", word_ct_o, 16'd1);
    check("mrst_err_cnt_after", error_counter_o, n_err_model);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
